// File: rtl/reg_scoreboard_pkg.sv
// Shared opcode and field definitions for the register scoreboard and its write decoder.
package reg_scoreboard_pkg;

    localparam int unsigned REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // Instruction type field values (instr[31:27]), shared with the read detector.
    localparam logic [4:0] INSTR_LOAD   = 5'h01;
    localparam logic [4:0] INSTR_STORE  = 5'h02;
    localparam logic [4:0] INSTR_ALU_OP = 5'h03;
    localparam logic [4:0] INSTR_JUMP   = 5'h04;

    localparam int unsigned TYPE_MSB    = 31;
    localparam int unsigned TYPE_LSB    = 27;
    localparam int unsigned ALU_RD_MSB  = 16;
    localparam int unsigned ALU_RD_LSB  = 12;
    localparam int unsigned LOAD_RD_MSB = 21;
    localparam int unsigned LOAD_RD_LSB = 17;

    function automatic logic [31:0] reg_onehot(input reg_idx_t idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode-side issue handshake and writeback retire port of the register scoreboard.
interface reg_scoreboard_if;

    logic        issue_valid;
    logic [31:0] issue_instr;
    logic        reads_0;
    logic        reads_1;
    logic [4:0]  read_reg_0;
    logic [4:0]  read_reg_1;
    logic        issue_ready;
    logic        wb_valid;
    logic [4:0]  wb_reg;

    modport master (
        output issue_valid,
        output issue_instr,
        output reads_0,
        output reads_1,
        output read_reg_0,
        output read_reg_1,
        input  issue_ready,
        output wb_valid,
        output wb_reg
    );

    modport slave (
        input  issue_valid,
        input  issue_instr,
        input  reads_0,
        input  reads_1,
        input  read_reg_0,
        input  read_reg_1,
        output issue_ready,
        input  wb_valid,
        input  wb_reg
    );

endinterface

// File: rtl/reg_scoreboard_write_detector.sv
// Combinational destination-register decode; mirrors the read detector's type decode.
module write_detector
    import reg_scoreboard_pkg::*;
(
    input  logic [31:0] instr,
    output logic        writes,
    output logic [4:0]  write_reg
);

    logic [4:0] op;
    logic       unused_bits;

    assign op          = instr[TYPE_MSB:TYPE_LSB];
    assign unused_bits = ^{instr[26:22], instr[11:0]};

    always_comb begin
        writes    = 1'b0;
        write_reg = '0;
        case (op)
            INSTR_ALU_OP: begin
                writes    = 1'b1;
                write_reg = instr[ALU_RD_MSB:ALU_RD_LSB];
            end
            INSTR_LOAD: begin
                writes    = 1'b1;
                write_reg = instr[LOAD_RD_MSB:LOAD_RD_LSB];
            end
            INSTR_STORE, INSTR_JUMP: begin
                writes    = 1'b0;
                write_reg = '0;
            end
            default: begin
                writes    = 1'b0;
                write_reg = '0;
            end
        endcase
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register write scoreboard: busy tracking, RAW/WAW issue gating, stall and error status.
// Optional SCOREBOARD_WB_BYPASS_EN lets a same-cycle writeback release its register's hazard.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned NREGS       = 32,
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    reg_scoreboard_if.slave        bus,
    output logic [NREGS-1:0]       busy,
    output logic [5:0]             outstanding,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic                   wb_err
);

    logic                   writes;
    logic [4:0]             write_reg;

    logic [NREGS-1:0]       busy_q;
    logic [5:0]             outstanding_q;
    logic [STALL_CNT_W-1:0] stall_q;
    logic                   wb_err_q;

    logic [31:0]            busy_full;
    logic [31:0]            hazard_busy;
    logic [31:0]            busy_nxt_full;
    logic                   raw0, raw1, waw;
    logic                   fire;
    logic                   set_en, clr_en, wb_bad;

    write_detector u_write_detector (
        .instr     (bus.issue_instr),
        .writes    (writes),
        .write_reg (write_reg)
    );

    // Widen to the full 5-bit index space so any register index is a legal lookup.
    always_comb begin
        busy_full              = '0;
        busy_full[NREGS-1:0]   = busy_q;
    end

`ifdef SCOREBOARD_WB_BYPASS_EN
    always_comb begin
        hazard_busy = busy_full;
        if (bus.wb_valid) begin
            hazard_busy = busy_full & ~reg_onehot(bus.wb_reg);
        end
    end
`else
    assign hazard_busy = busy_full;
`endif

    assign raw0 = bus.reads_0 && hazard_busy[bus.read_reg_0];
    assign raw1 = bus.reads_1 && hazard_busy[bus.read_reg_1];
    assign waw  = writes && hazard_busy[write_reg];

    assign bus.issue_ready = !(raw0 || raw1 || waw);
    assign fire            = bus.issue_valid && bus.issue_ready;

    assign set_en = fire && writes && (write_reg != 5'd0) && (32'(write_reg) < NREGS);
    assign clr_en = bus.wb_valid && (bus.wb_reg != 5'd0) && busy_full[bus.wb_reg];
    assign wb_bad = bus.wb_valid && (bus.wb_reg != 5'd0) && !busy_full[bus.wb_reg];

    // Clear first, then set, so a same-register set+clear (bypass only) leaves the bit set.
    always_comb begin
        busy_nxt_full = busy_full;
        if (clr_en) begin
            busy_nxt_full[bus.wb_reg] = 1'b0;
        end
        if (set_en) begin
            busy_nxt_full[write_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt_full[NREGS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            outstanding_q <= '0;
        end else begin
            case ({set_en, clr_en})
                2'b10:   outstanding_q <= outstanding_q + 6'd1;
                2'b01:   outstanding_q <= outstanding_q - 6'd1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (bus.issue_valid && !bus.issue_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_err_q <= 1'b0;
        end else if (wb_bad) begin
            wb_err_q <= 1'b1;
        end
    end

    assign busy         = busy_q;
    assign outstanding  = outstanding_q;
    assign stall_cycles = stall_q;
    assign wb_err       = wb_err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard (STALL_CNT_W=4); expectations follow SCOREBOARD_WB_BYPASS_EN.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] busy;
    logic [5:0]  outstanding;
    logic [3:0]  stall_cycles;
    logic        wb_err;

    int unsigned errors;
    int unsigned checks;

    reg_scoreboard_if bus ();

    reg_scoreboard #(
        .NREGS       (32),
        .STALL_CNT_W (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .busy         (busy),
        .outstanding  (outstanding),
        .stall_cycles (stall_cycles),
        .wb_err       (wb_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd);
        logic [31:0] w;
        w        = '0;
        w[31:27] = op;
        if (op == INSTR_ALU_OP) w[16:12] = rd;
        if (op == INSTR_LOAD)   w[21:17] = rd;
        return w;
    endfunction

    task automatic drive(input logic iv, input logic [31:0] instr,
                         input logic r0en, input logic [4:0] r0,
                         input logic r1en, input logic [4:0] r1,
                         input logic wbv, input logic [4:0] wbr);
        bus.issue_valid = iv;
        bus.issue_instr = instr;
        bus.reads_0     = r0en;
        bus.read_reg_0  = r0;
        bus.reads_1     = r1en;
        bus.read_reg_1  = r1;
        bus.wb_valid    = wbv;
        bus.wb_reg      = wbr;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        idle();

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            drive(1'($urandom), $urandom, 1'($urandom), 5'($urandom),
                  1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom));
            tick();
        end
        drive(1'b1, mk(INSTR_LOAD, 5'd5), 1'b1, 5'd1, 1'b1, 5'd2, 1'b0, 5'd0);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out", 64'(outstanding), 64'd0);
        chk("rst_stall", 64'(stall_cycles), 64'd0);
        chk("rst_wberr", 64'(wb_err), 64'd0);
        chk("rst_ready", 64'(bus.issue_ready), 64'd1);
        idle();
        rst = 1'b1;
        tick();

        // RAW on r5
        drive(1'b1, mk(INSTR_ALU_OP, 5'd5), 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        #1 chk("raw_first_ready", 64'(bus.issue_ready), 64'd1);
        tick();
        chk("raw_busy5", 64'(busy), 64'h20);
        chk("raw_out1", 64'(outstanding), 64'd1);
        drive(1'b1, mk(INSTR_LOAD, 5'd6), 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
        #1 chk("raw_stall_ready", 64'(bus.issue_ready), 64'd0);
        tick();
        tick();
        chk("raw_stall2", 64'(stall_cycles), 64'd2);
        drive(1'b1, mk(INSTR_LOAD, 5'd6), 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5);
`ifdef SCOREBOARD_WB_BYPASS_EN
        #1 chk("raw_wb_ready", 64'(bus.issue_ready), 64'd1);
        tick();
        chk("raw_issue_busy", 64'(busy), 64'h40);
        chk("raw_issue_out", 64'(outstanding), 64'd1);
        chk("raw_issue_stall", 64'(stall_cycles), 64'd2);
`else
        #1 chk("raw_wb_ready", 64'(bus.issue_ready), 64'd0);
        tick();
        chk("raw_wb_busy", 64'(busy), 64'h0);
        chk("raw_wb_stall", 64'(stall_cycles), 64'd3);
        drive(1'b1, mk(INSTR_LOAD, 5'd6), 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
        #1 chk("raw_after_ready", 64'(bus.issue_ready), 64'd1);
        tick();
        chk("raw_issue_busy", 64'(busy), 64'h40);
        chk("raw_issue_out", 64'(outstanding), 64'd1);
        chk("raw_issue_stall", 64'(stall_cycles), 64'd3);
`endif
        drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd6);
        tick();
        chk("raw_clean_busy", 64'(busy), 64'h0);
        chk("raw_clean_out", 64'(outstanding), 64'd0);

        // WAW on r7
        drive(1'b1, mk(INSTR_ALU_OP, 5'd7), 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        chk("waw_busy7", 64'(busy), 64'h80);
        #1 chk("waw_ready", 64'(bus.issue_ready), 64'd0);
        drive(1'b1, mk(INSTR_ALU_OP, 5'd7), 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7);
`ifdef SCOREBOARD_WB_BYPASS_EN
        #1 chk("waw_wb_ready", 64'(bus.issue_ready), 64'd1);
        tick();
`else
        #1 chk("waw_wb_ready", 64'(bus.issue_ready), 64'd0);
        tick();
        chk("waw_wb_busy", 64'(busy), 64'h0);
        drive(1'b1, mk(INSTR_ALU_OP, 5'd7), 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        #1 chk("waw_after_ready", 64'(bus.issue_ready), 64'd1);
        tick();
`endif
        chk("waw_issue_busy", 64'(busy), 64'h80);
        chk("waw_issue_out", 64'(outstanding), 64'd1);
        drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7);
        tick();
        chk("waw_clean_busy", 64'(busy), 64'h0);

        // Concurrent retire r3 and issue r4
        drive(1'b1, mk(INSTR_ALU_OP, 5'd3), 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        chk("conc_busy3", 64'(busy), 64'h8);
        drive(1'b1, mk(INSTR_ALU_OP, 5'd4), 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3);
        #1 chk("conc_ready", 64'(bus.issue_ready), 64'd1);
        tick();
        chk("conc_busy4", 64'(busy), 64'h10);
        chk("conc_out", 64'(outstanding), 64'd1);
        drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4);
        tick();
        chk("conc_clean_out", 64'(outstanding), 64'd0);
        chk("conc_wberr", 64'(wb_err), 64'd0);

        // Spurious writeback and r0 handling
        drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9);
        tick();
        chk("err_set", 64'(wb_err), 64'd1);
        idle();
        tick();
        tick();
        chk("err_sticky", 64'(wb_err), 64'd1);
        drive(1'b1, mk(INSTR_ALU_OP, 5'd0), 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        #1 chk("r0_ready", 64'(bus.issue_ready), 64'd1);
        tick();
        chk("r0_busy", 64'(busy), 64'h0);
        chk("r0_out", 64'(outstanding), 64'd0);
        drive(1'b1, mk(INSTR_ALU_OP, 5'd0), 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0);
        #1 chk("r0_no_hazard", 64'(bus.issue_ready), 64'd1);

        // Reset clears sticky error; r0 retire ignored
        idle();
        rst = 1'b0;
        tick();
        chk("rst2_wberr", 64'(wb_err), 64'd0);
        chk("rst2_stall", 64'(stall_cycles), 64'd0);
        rst = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0);
        tick();
        chk("wb_r0_noerr", 64'(wb_err), 64'd0);

        // Stall counter saturation at 15 (4-bit build), then reset mid-stall
        drive(1'b1, mk(INSTR_ALU_OP, 5'd2), 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        chk("sat_busy2", 64'(busy), 64'h4);
        repeat (15) tick();
        chk("sat_reach", 64'(stall_cycles), 64'd15);
        repeat (6) tick();
        chk("sat_hold", 64'(stall_cycles), 64'd15);
        chk("sat_ready", 64'(bus.issue_ready), 64'd0);
        rst = 1'b0;
        tick();
        chk("midstall_rst_stall", 64'(stall_cycles), 64'd0);
        chk("midstall_rst_busy", 64'(busy), 64'h0);
        chk("midstall_rst_out", 64'(outstanding), 64'd0);
        chk("midstall_ready", 64'(bus.issue_ready), 64'd1);
        idle();
        rst = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
Write-side counterpart to the register read detector. It decodes the destination register of each issuing instruction, marks it busy until writeback and gates issue on RAW/WAW hazards. It sits between decode and execute. It consumes the read detector's reads_*/read_reg_* outputs and the writeback-stage retire port.

Parameters:
NREGS, 32, number of architectural registers tracked (register index width fixed at 5).
STALL_CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-low reset
issue_valid  input  1  decode presents an instruction
issue_instr  input  32  instruction word; type in [31:27]
reads_0  input  1  from read detector: instruction reads read_reg_0
reads_1  input  1  from read detector: instruction reads read_reg_1
read_reg_0  input  5  first source register
read_reg_1  input  5  second source register
issue_ready  output  1  no hazard; issue fires when issue_valid && issue_ready
wb_valid  input  1  writeback retires a register write
wb_reg  input  5  register being written back
busy  output  NREGS  pending-write bit per register
outstanding  output  6  count of busy registers (0..32)
stall_cycles  output  STALL_CNT_W  cycles with issue_valid && !issue_ready, saturating
wb_err  output  1  sticky: writeback to a non-busy register

Behaviour:
- Reset (rst==0 at a clk edge): busy=0, outstanding=0, stall_cycles=0, wb_err=0. Reset overrides all same-cycle events, including mid-stall.
- Write decode (combinational):
  - `INSTR_ALU_OP writes instr[16:12].
  - `INSTR_LOAD writes instr[21:17].
  - `INSTR_STORE, `INSTR_JUMP and all other types write nothing.
- Register 0 is never marked busy and never causes a hazard. A wb_reg==0 retire is ignored and does not raise wb_err.
- Hazard terms: raw0 = reads_0 && busy[read_reg_0]; raw1 = reads_1 && busy[read_reg_1]; waw = writes && busy[write_reg].
- issue_ready = !(raw0||raw1||waw). It is combinational and is driven regardless of issue_valid.
- On an issue fire with writes && write_reg!=0, busy[write_reg] sets at the next edge.
- On wb_valid, busy[wb_reg] clears at the next edge. If that bit is already 0, wb_err sets (sticky until reset).
- Same-register set and clear in one cycle: impossible without bypass, because waw blocks the issue. With bypass, the set wins: the bit stays 1 and outstanding is unchanged.
- outstanding updates as +1 on a set, −1 on a valid clear, net 0 when both happen. It always equals popcount(busy). No overflow is possible.
- stall_cycles increments each cycle issue_valid && !issue_ready holds, and saturates at all-ones.
- Latency: a set or clear becomes visible to issue_ready one cycle after the edge (no bypass).

Optional Feature:
SCOREBOARD_WB_BYPASS_EN
- Defined: a same-cycle wb_valid masks busy[wb_reg] in the hazard terms, so a dependent instruction issues in the writeback cycle. Same-register set+clear resolves to set.
- Undefined: hazards use registered busy only. The dependent instruction issues the cycle after writeback.

Decomposition:
- Shared definitions header: `INSTR_LOAD, `INSTR_STORE, `INSTR_ALU_OP, `INSTR_JUMP opcodes. Add the destination-field bit positions as named constants.
- Sub-module write_detector: combinational, instr[31:0] -> writes, write_reg[4:0]. It mirrors the read detector's decode.
- reg_scoreboard instantiates write_detector and holds the busy vector, the outstanding counter, the stall counter and the wb_err flag.

Test Plan:
- Reset: drive rst=0 for 2 cycles with random inputs -> busy=0, outstanding=0, stall_cycles=0, wb_err=0, issue_ready=1 for any instruction.
- RAW: issue ALU_OP writing r5, then LOAD with read_reg_0=5, reads_0=1 -> issue_ready=0 and stall_cycles counts. wb r5 -> ready the next cycle (no bypass) or the same cycle (bypass).
- WAW: r7 busy; ALU_OP writing r7 with reads_0=reads_1=0 -> issue_ready=0. After wb r7 it issues, busy[7]=1 and outstanding=1.
- Concurrent: r3 busy; the same cycle retires wb r3 and issues ALU_OP writing r4 -> busy[3]=0, busy[4]=1, outstanding unchanged.
- Errors/r0: wb r9 while not busy -> wb_err=1 and sticky. An ALU_OP writing r0 -> busy unchanged, no later hazard.
- Saturation: force a stall for 2^STALL_CNT_W+5 cycles (STALL_CNT_W=4 build) -> stall_cycles holds at 15.
